// File: rtl/wave_pkg.sv
// Shared definitions for the phase-accumulator waveform generator family:
// mode encodings and default widths.
package wave_pkg;

  localparam int DEF_PHASE_W = 16;
  localparam int DEF_FREQ_W  = 16;
  localparam int DEF_OUT_W   = 6;

  // Square duty after reset is 50 %.
  localparam logic [7:0] DUTY_RESET = 8'h80;

  typedef enum logic [1:0] {
    MODE_SQR = 2'd0,
    MODE_SAW = 2'd1,
    MODE_TRI = 2'd2,
    MODE_DC  = 2'd3
  } wave_mode_e;

endpackage

// File: rtl/wave_shaper.sv
// Combinational phase -> sample mapping for square, saw, triangle and DC.
// Holds no state, so one copy can serve each channel of a wrapper.
module wave_shaper
  import wave_pkg::*;
#(
  parameter int PHASE_W = DEF_PHASE_W,
  parameter int OUT_W   = DEF_OUT_W
) (
  input  logic [PHASE_W-1:0] phase_i,
  input  logic [1:0]         mode_i,
  input  logic [7:0]         duty_i,
  output logic [OUT_W-1:0]   sample_o
);

  logic [PHASE_W-1:0] duty_thr;
  logic [OUT_W-1:0]   tri_t;

  // Duty is the top byte of the phase threshold.
  assign duty_thr = PHASE_W'(duty_i) << (PHASE_W - 8);
  assign tri_t    = phase_i[PHASE_W-2 -: OUT_W];

  always_comb begin
    sample_o = '0;
    case (wave_mode_e'(mode_i))
      MODE_SQR: sample_o = (phase_i < duty_thr) ? {OUT_W{1'b1}} : '0;
      MODE_SAW: sample_o = phase_i[PHASE_W-1 -: OUT_W];
      MODE_TRI: sample_o = phase_i[PHASE_W-1] ? ~tri_t : tri_t;
      MODE_DC:  sample_o[OUT_W-1] = 1'b1;
      default:  sample_o = '0;
    endcase
  end

endmodule

// File: rtl/param_wave_gen.sv
// Phase-accumulator waveform generator. Frequency, mode and duty are shadowed
// and only take effect at a period boundary (wrap) or on sync.
module param_wave_gen
  import wave_pkg::*;
#(
  parameter int PHASE_W = DEF_PHASE_W,
  parameter int FREQ_W  = DEF_FREQ_W,
  parameter int OUT_W   = DEF_OUT_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               en,
  input  logic               sync,
  input  logic [FREQ_W-1:0]  freq,
  input  logic [1:0]         mode,
  input  logic [7:0]         duty,
  output logic [OUT_W-1:0]   wave_out,
  output logic               wrap,
  output logic [PHASE_W-1:0] phase_out
);

  logic [PHASE_W-1:0] phase_q, phase_d;
  logic [OUT_W-1:0]   wave_q, wave_d;
  logic               wrap_q, wrap_d;
  logic [FREQ_W-1:0]  freq_s_q, freq_s_d;
  logic [1:0]         mode_s_q, mode_s_d;
  logic [7:0]         duty_s_q, duty_s_d;

  logic [PHASE_W:0]   sum;
  logic [OUT_W-1:0]   shape;
  logic               load_shadow;

  // One extra bit so the carry-out is the wrap flag.
  assign sum = {1'b0, phase_q} + (PHASE_W + 1)'(freq_s_q);

  wave_shaper #(
    .PHASE_W (PHASE_W),
    .OUT_W   (OUT_W)
  ) u_shaper (
    .phase_i  (phase_q),
    .mode_i   (mode_s_q),
    .duty_i   (duty_s_q),
    .sample_o (shape)
  );

  always_comb begin
    phase_d     = phase_q;
    wave_d      = wave_q;
    wrap_d      = 1'b0;
    load_shadow = 1'b0;
    if (sync) begin
      phase_d     = '0;
      load_shadow = 1'b1;
      if (en) wave_d = shape;
    end else if (en) begin
      phase_d     = sum[PHASE_W-1:0];
      wrap_d      = sum[PHASE_W];
      load_shadow = sum[PHASE_W];
      wave_d      = shape;
    end else begin
      load_shadow = 1'b1;
    end
    freq_s_d = load_shadow ? freq : freq_s_q;
    mode_s_d = load_shadow ? mode : mode_s_q;
    duty_s_d = load_shadow ? duty : duty_s_q;
  end

  // Everything updates on the falling edge of clk.
  always_ff @(negedge clk or negedge reset) begin
    if (!reset) begin
      phase_q  <= '0;
      wave_q   <= '0;
      wrap_q   <= 1'b0;
      freq_s_q <= '0;
      mode_s_q <= MODE_SQR;
      duty_s_q <= DUTY_RESET;
    end else begin
      phase_q  <= phase_d;
      wave_q   <= wave_d;
      wrap_q   <= wrap_d;
      freq_s_q <= freq_s_d;
      mode_s_q <= mode_s_d;
      duty_s_q <= duty_s_d;
    end
  end

  assign wave_out  = wave_q;
  assign wrap      = wrap_q;
  assign phase_out = phase_q;

endmodule

// File: tb/tb_param_wave_gen.sv
// Bench for param_wave_gen: vector table, hand-written corner sequences and
// randomized stimulus against an arithmetic reference model.
module tb_param_wave_gen;

  localparam int PHASE_W = 16;
  localparam int FREQ_W  = 16;
  localparam int OUT_W   = 6;
  localparam int PERIOD  = 1 << PHASE_W;
  localparam int OUT_MAX = (1 << OUT_W) - 1;

  logic               clk = 1'b0;
  logic               reset = 1'b0;
  logic               en = 1'b1;
  logic               sync = 1'b0;
  logic [FREQ_W-1:0]  freq = '0;
  logic [1:0]         mode = '0;
  logic [7:0]         duty = '0;
  logic [OUT_W-1:0]   wave_out;
  logic               wrap;
  logic [PHASE_W-1:0] phase_out;

  param_wave_gen #(
    .PHASE_W (PHASE_W),
    .FREQ_W  (FREQ_W),
    .OUT_W   (OUT_W)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .en        (en),
    .sync      (sync),
    .freq      (freq),
    .mode      (mode),
    .duty      (duty),
    .wave_out  (wave_out),
    .wrap      (wrap),
    .phase_out (phase_out)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state
  int m_phase, m_wave, m_wrap, m_freq, m_mode, m_duty;

  typedef struct {
    logic        en;
    logic        sync;
    logic [15:0] freq;
    logic [1:0]  mode;
    logic [7:0]  duty;
    logic [5:0]  exp_wave;
    logic        exp_wrap;
    logic [15:0] exp_phase;
  } vec_t;

  vec_t vecs[13];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  function automatic int exp_sample(input int ph, input int md, input int dt);
    int t;
    case (md)
      0: return (ph < dt * (PERIOD / 256)) ? OUT_MAX : 0;
      1: return ph / (PERIOD >> OUT_W);
      2: begin
        t = (ph % (PERIOD / 2)) / ((PERIOD / 2) >> OUT_W);
        return (ph >= PERIOD / 2) ? OUT_MAX - t : t;
      end
      default: return (OUT_MAX + 1) / 2;
    endcase
  endfunction

  task automatic model_reset();
    m_phase = 0; m_wave = 0; m_wrap = 0;
    m_freq = 0; m_mode = 0; m_duty = 128;
  endtask

  task automatic model_edge();
    int  shape, total;
    bit  load;
    shape = exp_sample(m_phase, m_mode, m_duty);
    load  = 0;
    if (sync) begin
      m_phase = 0; m_wrap = 0; load = 1;
    end else if (en) begin
      total   = m_phase + m_freq;
      m_phase = total % PERIOD;
      m_wrap  = (total >= PERIOD) ? 1 : 0;
      load    = (m_wrap == 1);
    end else begin
      m_wrap = 0; load = 1;
    end
    if (en) m_wave = shape;
    if (load) begin
      m_freq = int'(freq); m_mode = int'(mode); m_duty = int'(duty);
    end
  endtask

  task automatic edge_check();
    @(negedge clk);
    model_edge();
    #1;
    check("phase", 32'(phase_out), 32'(m_phase));
    check("wave",  32'(wave_out),  32'(m_wave));
    check("wrap",  32'(wrap),      32'(m_wrap));
  endtask

  task automatic step(input logic e, input logic s, input int f, input int md, input int dt);
    @(posedge clk);
    en = e; sync = s; freq = 16'(f); mode = 2'(md); duty = 8'(dt);
    edge_check();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int r, f, dt;
    // en, sync, freq, mode, duty | wave, wrap, phase
    vecs[0]  = '{1'b1, 1'b1, 16'h3000, 2'd1, 8'h80, 6'd63, 1'b0, 16'h0000};
    vecs[1]  = '{1'b1, 1'b0, 16'h3000, 2'd1, 8'h80, 6'd0,  1'b0, 16'h3000};
    vecs[2]  = '{1'b1, 1'b0, 16'h3000, 2'd1, 8'h80, 6'd12, 1'b0, 16'h6000};
    vecs[3]  = '{1'b1, 1'b0, 16'h3000, 2'd1, 8'h80, 6'd24, 1'b0, 16'h9000};
    vecs[4]  = '{1'b1, 1'b0, 16'h3000, 2'd1, 8'h80, 6'd36, 1'b0, 16'hC000};
    vecs[5]  = '{1'b1, 1'b0, 16'h3000, 2'd1, 8'h80, 6'd48, 1'b0, 16'hF000};
    vecs[6]  = '{1'b1, 1'b0, 16'h3000, 2'd1, 8'h80, 6'd60, 1'b1, 16'h2000};
    vecs[7]  = '{1'b1, 1'b0, 16'h3000, 2'd1, 8'h80, 6'd8,  1'b0, 16'h5000};
    vecs[8]  = '{1'b0, 1'b0, 16'h1000, 2'd2, 8'h80, 6'd8,  1'b0, 16'h5000};
    vecs[9]  = '{1'b0, 1'b0, 16'h1000, 2'd2, 8'h80, 6'd8,  1'b0, 16'h5000};
    vecs[10] = '{1'b1, 1'b1, 16'h1000, 2'd2, 8'h80, 6'd40, 1'b0, 16'h0000};
    vecs[11] = '{1'b1, 1'b0, 16'h1000, 2'd2, 8'h80, 6'd0,  1'b0, 16'h1000};
    vecs[12] = '{1'b1, 1'b0, 16'h1000, 2'd2, 8'h80, 6'd8,  1'b0, 16'h2000};

    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("reset_phase", 32'(phase_out), 32'd0);
    check("reset_wave",  32'(wave_out),  32'd0);
    check("reset_wrap",  32'(wrap),      32'd0);

    // First edge after release: phase 0 with reset shadows (square, 50 %).
    @(posedge clk);
    reset = 1'b1;
    edge_check();
    check("release_wave", 32'(wave_out), 32'd63);

    for (int i = 0; i < 13; i++) begin
      @(posedge clk);
      en = vecs[i].en; sync = vecs[i].sync; freq = vecs[i].freq;
      mode = vecs[i].mode; duty = vecs[i].duty;
      @(negedge clk);
      model_edge();
      #1;
      check("vec_phase", 32'(phase_out), 32'(vecs[i].exp_phase));
      check("vec_wave",  32'(wave_out),  32'(vecs[i].exp_wave));
      check("vec_wrap",  32'(wrap),      32'(vecs[i].exp_wrap));
    end

    // 50 % square at 16 edges per period, two full periods.
    step(1'b1, 1'b1, 'h1000, 0, 'h80);
    repeat (32) step(1'b1, 1'b0, 'h1000, 0, 'h80);

    // Mode and rate change mid-period: old square finishes first.
    repeat (5) step(1'b1, 1'b0, 'h1000, 0, 'h80);
    repeat (20) step(1'b1, 1'b0, 'h2000, 1, 'h80);

    // Frozen while disabled.
    repeat (5) step(1'b0, 1'b0, 'h2000, 1, 'h80);

    // Stuck phase with zero tuning word.
    step(1'b1, 1'b1, 0, 2, 'h80);
    repeat (4) step(1'b1, 1'b0, 0, 2, 'h80);

    // Duty extremes.
    step(1'b1, 1'b1, 'h0100, 0, 'hFF);
    repeat (258) step(1'b1, 1'b0, 'h0100, 0, 'hFF);
    step(1'b1, 1'b1, 'h1000, 0, 'h00);
    repeat (18) step(1'b1, 1'b0, 'h1000, 0, 'h00);

    // DC midscale.
    step(1'b1, 1'b1, 'h1000, 3, 'h80);
    repeat (3) step(1'b1, 1'b0, 'h1000, 3, 'h80);
    check("dc_wave", 32'(wave_out), 32'd32);

    // Sync at phase 0x7000.
    step(1'b1, 1'b1, 'h1000, 0, 'h80);
    repeat (7) step(1'b1, 1'b0, 'h1000, 0, 'h80);
    check("pre_sync_phase", 32'(phase_out), 32'h7000);
    step(1'b1, 1'b1, 'h1000, 0, 'h80);
    check("sync_phase", 32'(phase_out), 32'd0);
    check("sync_wrap",  32'(wrap),      32'd0);

    // Asynchronous reset at phase 0x9000, checked between clock edges.
    repeat (9) step(1'b1, 1'b0, 'h1000, 0, 'h80);
    check("pre_reset_phase", 32'(phase_out), 32'h9000);
    #2;
    reset = 1'b0;
    #1;
    check("async_reset_phase", 32'(phase_out), 32'd0);
    check("async_reset_wave",  32'(wave_out),  32'd0);
    check("async_reset_wrap",  32'(wrap),      32'd0);
    model_reset();
    @(posedge clk);
    reset = 1'b1;
    edge_check();
    check("rerelease_wave", 32'(wave_out), 32'd63);

    // Randomized run against the model.
    step(1'b1, 1'b1, 'h0800, 1, 'h80);
    for (int i = 0; i < 3000; i++) begin
      r = int'($urandom_range(0, 19));
      if (r == 0)      f = 0;
      else if (r < 10) f = int'($urandom_range(1, 'h0800));
      else             f = int'($urandom_range(0, 'hFFFF));
      r = int'($urandom_range(0, 9));
      if (r == 0)      dt = 0;
      else if (r == 1) dt = 255;
      else             dt = int'($urandom_range(0, 255));
      step(($urandom_range(0, 9) != 0), ($urandom_range(0, 49) == 0),
           f, int'($urandom_range(0, 3)), dt);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/param_wave_gen.md
Name: param_wave_gen

Overview:
- Parametrised phase-accumulator waveform generator; successor to the fixed-table square generator.
- Produces square (programmable duty), sawtooth, triangle or midscale DC from a power-of-two phase accumulator, with true modulo wrap and no table memory.
- Frequency, mode and duty changes take effect only at the period boundary, so output periods are never truncated.
- Sits between the control/USART register block and the DSP/VGA display path; one instance per channel.

Parameters:
- PHASE_W, 16, phase accumulator width; period = 2**PHASE_W phase units.
- FREQ_W, 16, tuning word width; must be <= PHASE_W.
- OUT_W, 6, output sample width; must be <= PHASE_W-1.

Ports:
- clk  in  1  system clock; all registers update on the falling edge.
- reset  in  1  asynchronous, active-low reset.
- en  in  1  run enable; 0 freezes phase and output.
- sync  in  1  phase restart request.
- freq  in  FREQ_W  tuning word (phase increment per enabled cycle).
- mode  in  2  0=square, 1=saw, 2=triangle, 3=DC midscale.
- duty  in  8  square high-time fraction, duty/256.
- wave_out  out  OUT_W  unsigned sample, registered.
- wrap  out  1  one-cycle pulse on accumulator wrap.
- phase_out  out  PHASE_W  current accumulator value, for debug and multi-channel alignment.

Behaviour:
- Clock and reset: one clock `clk`; reset is asynchronous and active-low on `reset`.
- Reset values: phase=0, wave_out=0, wrap=0. Shadow registers: freq_s=0, mode_s=0, duty_s=0x80.
- Shadow load:
  - freq_s, mode_s and duty_s load from the inputs on every edge where en=0.
  - While en=1 they load only on an edge where wrap is being asserted or sync=1.
- Phase update while en=1:
  - phase <= (phase + freq_s) mod 2**PHASE_W, computed with a PHASE_W+1 bit add.
  - wrap <= the carry-out of that add.
  - freq_s=0 holds phase and never wraps.
- Sync: sync=1 (any en) forces phase<=0, wrap<=0, and reloads the shadows. Sync has priority over accumulation.
- en=0: phase and wave_out hold; wrap<=0.
- Output: registered from the pre-update phase and the current shadows, so wave_out lags phase_out by one edge (latency 1).
  - Square: wave_out = all-ones if phase < {duty_s, (PHASE_W-8) zeros}, else 0. duty_s=0 gives constant 0; duty_s=255 gives low for 1/256 of the period.
  - Saw: wave_out = phase[PHASE_W-1 -: OUT_W].
  - Triangle: t = phase[PHASE_W-2 -: OUT_W]; wave_out = t when phase MSB=0, else ~t.
  - DC: wave_out = 2**(OUT_W-1).
- Mode or duty change while running: no effect until the next wrap or sync; the current period completes in the old mode.
- Reset mid-period: immediate return to the reset values; the first sample after release reflects phase 0 with the reset shadows.

Decomposition:
- Shared package wave_pkg holds:
  - mode encodings MODE_SQR=2'd0, MODE_SAW=2'd1, MODE_TRI=2'd2, MODE_DC=2'd3;
  - the default widths.
- One natural sub-module, wave_shaper: a combinational phase+mode+duty -> sample mapping, reusable by a future multi-channel wrapper.
- The accumulator and shadow logic stay in param_wave_gen.

Test Plan (defaults PHASE_W=16, OUT_W=6):
- Reset, en=1, freq=0x1000, mode=0, duty=0x80 -> wave_out = 63 for 8 samples then 0 for 8, period 16; wrap pulses every 16 edges.
- mode=1, freq=0x1000 after sync -> wave_out 0,4,8,…,60 repeating; wrap coincides with phase returning to 0.
- mode=2, freq=0x1000 -> wave_out 0,8,…,56,63,55,…,7 repeating.
- freq=0x3000 -> phase sequence 0,0x3000,…,0xF000,0x2000 (modulo wrap, not restart); wrap asserted on the 0xF000->0x2000 edge.
- Change mode 0->1 and freq mid-period -> square continues unchanged until the wrap edge, then saw at the new rate; en=0 for 5 edges -> wave_out and phase frozen, wrap=0.
- Assert sync at phase 0x7000 -> next phase 0, wrap=0; assert reset at phase 0x9000 -> wave_out=0 and phase=0 immediately, without waiting for a clock edge.
